vc_arbiter: RTL and testbench
=============================

# vc_arbiter

Round-robin scheduler that shares the single downstream link FIFO among the four virtual-channel input FIFOs supervised by the `fsm` block. Each cycle it selects at most one non-empty input FIFO, pops one word, and pushes that word into the output FIFO two cycles later. It honours the downstream almost-full back-pressure and the enable from `fsm`. It sits between the four VC FIFOs and the output FIFO, beside `fsm`.

## Interface

Parameters:
- DATA_WIDTH, 10, word width of every FIFO
- BURST_LEN, 4, maximum consecutive grants to one channel; used only when ARB_BURST_EN is defined

Ports:
- clk  in  1  single clock; all state updates on rising edge
- reset  in  1  asynchronous, active-low reset (0 = reset)
- arb_en  in  1  enable from `fsm`; 1 while in ACTIVE state
- in_empty  in  4  empty flags of VC FIFOs 3..0
- in_data0..in_data3  in  DATA_WIDTH each  read data of VC FIFO n, valid the cycle after its pop
- out_almost_full  in  1  output FIFO almost full (pause threshold)
- in_pop  out  4  one-hot pop to VC FIFOs; at most one bit set
- out_push  out  1  write strobe to output FIFO
- out_data  out  DATA_WIDTH  word written to output FIFO
- grant_id  out  2  index of last granted channel
- busy  out  1  1 while any word is in flight (pop issued, push not yet done)

## Operation

- Eligible channel n: in_empty[n]==0.
- Pop condition (cycle N): reset high, arb_en==1, out_almost_full==0, at least one eligible channel. in_pop is combinational from the registered state and the current inputs.
- Selection: first eligible channel at or after the round-robin pointer rr_ptr, searching ascending mod 4.
- After a grant to channel i: grant_id<=i; rr_ptr<=(i+1) mod 4 (see Configuration for burst mode).
- Pipeline: stage1 registers {valid, channel} at the end of cycle N. In cycle N+1, in_data of that channel is captured into out_data at the end of cycle N+1. out_push=1 during cycle N+2.
- State machine: IDLE (no pop this cycle), SERVE (pop issued), STALL (arb_en==1 and eligible channel exists but out_almost_full==1). Transitions are evaluated every cycle from the pop condition. busy = stage1 valid OR out_push.
- arb_en or out_almost_full deasserting/asserting stops new pops only. Words already popped always complete their push.
- The output FIFO must have at least 2 free entries when out_almost_full is low, because 2 words can be in flight.
- A channel going empty in the same cycle as its pop is not re-granted in the next cycle unless in_empty shows 0 again.
- Reset (async, any time): in_pop=0, out_push=0, out_data=0, grant_id=0, busy=0, rr_ptr=0, burst count=0, state IDLE. In-flight words are dropped.

## Timing

- Pop-to-push latency: exactly 2 cycles.
- Throughput: 1 word/cycle sustained while the pop condition holds.
- Back-pressure: out_almost_full high in cycle N blocks in_pop in cycle N. Pushes for pops from N-1 and N-2 still occur.
- First pop may occur in the first rising-edge cycle after reset releases.

## Configuration

- ARB_BURST_EN defined: after a grant to channel i, rr_ptr stays at i and a burst counter increments. rr_ptr moves to (i+1) mod 4, and the counter clears, when BURST_LEN grants have been made to i, or when i is not eligible at a selection. A cycle with no grant because of back-pressure does not reset the counter.
- ARB_BURST_EN undefined: strict one-word round robin; no burst counter is instantiated; BURST_LEN is ignored.

## Test plan

- Reset then all in_empty=4'b1111, arb_en=1 -> in_pop=0, out_push=0, busy=0, state IDLE for 10 cycles.
- All four channels non-empty, arb_en=1, no back-pressure, no burst -> in_pop sequence 0001,0010,0100,1000,0001. out_push starts 2 cycles after the first pop. out_data equals in_data0, in_data1, ... in order.
- Same stimulus with ARB_BURST_EN, BURST_LEN=4 -> in_pop=0001 for 4 cycles, then 0010 for 4 cycles. Channel 2 going empty after 2 grants -> pointer moves to channel 3 immediately.
- out_almost_full=1 for 3 cycles mid-stream -> in_pop=0 during those cycles, exactly 2 trailing pushes, state STALL. Round-robin resumes at the next channel after release.
- Only channel 2 non-empty -> in_pop=0100 every cycle, grant_id=2. arb_en dropping to 0 -> pops stop the same cycle, last 2 pushes complete, then busy=0.
- reset=0 asserted while busy=1 -> all outputs 0 immediately with no clock edge needed. After release, the first grant goes to channel 0 if it is eligible.

Source files
------------

// File: rtl/vc_arbiter_if.sv
// vc_arbiter_if: bundles the VC FIFO read side and the output FIFO write side
// seen by vc_arbiter. master = arbiter, slave = FIFO side.
interface vc_arbiter_if #(
    parameter int DATA_WIDTH = 10
);
    logic [3:0]            in_empty;
    logic [DATA_WIDTH-1:0] in_data0;
    logic [DATA_WIDTH-1:0] in_data1;
    logic [DATA_WIDTH-1:0] in_data2;
    logic [DATA_WIDTH-1:0] in_data3;
    logic [3:0]            in_pop;
    logic                  out_almost_full;
    logic                  out_push;
    logic [DATA_WIDTH-1:0] out_data;

    modport master (
        input  in_empty, in_data0, in_data1, in_data2, in_data3, out_almost_full,
        output in_pop, out_push, out_data
    );

    modport slave (
        output in_empty, in_data0, in_data1, in_data2, in_data3, out_almost_full,
        input  in_pop, out_push, out_data
    );
endinterface

// File: rtl/vc_arbiter.sv
// vc_arbiter: round-robin scheduler moving words from four VC FIFOs into the
// shared output FIFO. Pop in cycle N, read data captured at end of N+1,
// push during N+2. Optional burst mode selected by ARB_BURST_EN.
//
// state | meaning
// IDLE  | no pop this cycle
// SERVE | pop issued this cycle
// STALL | enabled with work pending but held off by out_almost_full
//
// arb_state reports the state decided for the previous cycle.
module vc_arbiter #(
    parameter int DATA_WIDTH = 10,
    parameter int BURST_LEN  = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        arb_en,
    vc_arbiter_if.master bus,
    output logic [1:0]  grant_id,
    output logic        busy,
    output logic [1:0]  arb_state
);
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SERVE = 2'd1,
        STALL = 2'd2
    } state_t;

    state_t                state;
    logic [1:0]            rr_ptr;
    logic [1:0]            sel_ch;
    logic [1:0]            s1_ch;
    logic                  s1_valid;
    logic                  push_r;
    logic [DATA_WIDTH-1:0] data_r;
    logic [DATA_WIDTH-1:0] s1_data;
    logic [3:0]            elig;
    logic                  any_elig;
    logic                  can_pop;

    if (BURST_LEN < 1) begin : g_bad_burst_len
        $error("vc_arbiter: BURST_LEN must be at least 1");
    end

    assign elig     = ~bus.in_empty;
    assign any_elig = |elig;
    // reset is part of the pop condition so in_pop drops with reset, no edge needed
    assign can_pop  = reset & arb_en & ~bus.out_almost_full & any_elig;

    // First eligible channel at or after rr_ptr, ascending mod 4
    always_comb begin
        logic [1:0] idx;
        logic       found;
        sel_ch = rr_ptr;
        found  = 1'b0;
        idx    = rr_ptr;
        for (int k = 0; k < 4; k++) begin
            idx = rr_ptr + 2'(k);
            if (!found && elig[idx]) begin
                found  = 1'b1;
                sel_ch = idx;
            end
        end
    end

    assign bus.in_pop = can_pop ? (4'b0001 << sel_ch) : 4'b0000;

    // Read-data mux for the channel popped last cycle
    always_comb begin
        case (s1_ch)
            2'd0:    s1_data = bus.in_data0;
            2'd1:    s1_data = bus.in_data1;
            2'd2:    s1_data = bus.in_data2;
            default: s1_data = bus.in_data3;
        endcase
    end

`ifdef ARB_BURST_EN
    localparam int CNT_W = $clog2(BURST_LEN + 1);

    logic [CNT_W-1:0] burst_cnt;
    logic [CNT_W-1:0] cnt_next;

    // A grant away from rr_ptr means the burst channel was not eligible: start afresh
    assign cnt_next = (sel_ch == rr_ptr) ? (burst_cnt + CNT_W'(1)) : CNT_W'(1);

    // Pointer stays on the granted channel until its burst is spent
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rr_ptr    <= 2'd0;
            burst_cnt <= '0;
        end else if (can_pop) begin
            if (cnt_next >= CNT_W'(BURST_LEN)) begin
                rr_ptr    <= sel_ch + 2'd1;
                burst_cnt <= '0;
            end else begin
                rr_ptr    <= sel_ch;
                burst_cnt <= cnt_next;
            end
        end
    end
`else
    // Strict one-word round robin
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rr_ptr <= 2'd0;
        end else if (can_pop) begin
            rr_ptr <= sel_ch + 2'd1;
        end
    end
`endif

    // Pop/capture/push pipeline and FSM; reset drops in-flight words
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            s1_valid <= 1'b0;
            s1_ch    <= 2'd0;
            push_r   <= 1'b0;
            data_r   <= '0;
            grant_id <= 2'd0;
            state    <= IDLE;
        end else begin
            s1_valid <= can_pop;
            if (can_pop) begin
                s1_ch    <= sel_ch;
                grant_id <= sel_ch;
            end
            push_r <= s1_valid;
            if (s1_valid) begin
                data_r <= s1_data;
            end
            if (can_pop) begin
                state <= SERVE;
            end else if (arb_en && any_elig && bus.out_almost_full) begin
                state <= STALL;
            end else begin
                state <= IDLE;
            end
        end
    end

    assign bus.out_push = push_r;
    assign bus.out_data = data_r;
    assign busy         = s1_valid | push_r;
    assign arb_state    = state;
endmodule

// File: tb/tb_vc_arbiter.sv
// tb_vc_arbiter: directed vectors for vc_arbiter. Each row gives the inputs of
// one cycle and the hand-written expected in_pop and FSM state; pushes, data,
// grant_id and busy are derived from the expected pops.
`timescale 1ns/1ps
module tb_vc_arbiter;
    localparam int DW = 10;
    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_SERVE = 2'd1;
    localparam logic [1:0] ST_STALL = 2'd2;
    localparam logic [1:0] ST_DC    = 2'd3;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       arb_en = 1'b0;
    logic [1:0] grant_id;
    logic       busy;
    logic [1:0] arb_state;

    int n_checks = 0;
    int n_errors = 0;

    vc_arbiter_if #(.DATA_WIDTH(DW)) bus ();

    vc_arbiter #(.DATA_WIDTH(DW), .BURST_LEN(4)) dut (
        .clk       (clk),
        .reset     (reset),
        .arb_en    (arb_en),
        .bus       (bus),
        .grant_id  (grant_id),
        .busy      (busy),
        .arb_state (arb_state)
    );

    always #5 clk = ~clk;

    // VC FIFO model: each pop returns the next word of that channel next cycle
    logic [DW-1:0] vc_data [4];
    int            vc_seq  [4];

    function automatic logic [DW-1:0] word(input int ch, input int s);
        return DW'(ch * 256 + s + 1);
    endfunction

    function automatic int onehot_idx(input logic [3:0] oh);
        case (oh)
            4'b0010: return 1;
            4'b0100: return 2;
            4'b1000: return 3;
            default: return 0;
        endcase
    endfunction

    always @(posedge clk) begin
        for (int ch = 0; ch < 4; ch++) begin
            if (!reset) begin
                vc_seq[ch]  <= 0;
                vc_data[ch] <= '0;
            end else if (bus.in_pop[ch]) begin
                vc_data[ch] <= word(ch, vc_seq[ch]);
                vc_seq[ch]  <= vc_seq[ch] + 1;
            end
        end
    end

    assign bus.in_data0 = vc_data[0];
    assign bus.in_data1 = vc_data[1];
    assign bus.in_data2 = vc_data[2];
    assign bus.in_data3 = vc_data[3];

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    // Leaves the bench 1ns after a rising edge with reset released
    task automatic do_reset();
        reset               = 1'b0;
        arb_en              = 1'b0;
        bus.in_empty        = 4'hF;
        bus.out_almost_full = 1'b0;
        @(posedge clk);
        @(posedge clk);
        #1;
        reset = 1'b1;
    endtask

    logic [3:0] v_empty [32];
    logic       v_af    [32];
    logic       v_en    [32];
    logic [3:0] v_pop   [32];
    logic [1:0] v_st    [32];

    task automatic set_row(input int c, input logic [3:0] emp, input logic af, input logic en,
                           input logic [3:0] pop, input logic [1:0] st);
        v_empty[c] = emp;
        v_af[c]    = af;
        v_en[c]    = en;
        v_pop[c]   = pop;
        v_st[c]    = st;
    endtask

    // Runs rows 0..n-1 right after do_reset, then 3 drain cycles with arb_en=0
    task automatic run_vec(input string name, input int n);
        logic [3:0] hist [40];
        int         seq_m [4];
        logic [1:0] last_gid;
        last_gid = 2'd0;
        for (int i = 0; i < 4; i++) seq_m[i] = 0;
        for (int c = 0; c < n + 3; c++) begin
            logic [3:0] ep;
            logic [3:0] p1;
            logic [3:0] p2;
            int         ch;
            if (c < n) begin
                bus.in_empty        = v_empty[c];
                bus.out_almost_full = v_af[c];
                arb_en              = v_en[c];
                ep                  = v_pop[c];
            end else begin
                arb_en = 1'b0;
                ep     = 4'b0000;
            end
            p1 = (c >= 1) ? hist[c-1] : 4'b0000;
            p2 = (c >= 2) ? hist[c-2] : 4'b0000;
            @(negedge clk);
            check_val($sformatf("%s in_pop c%0d", name, c), bus.in_pop, ep);
            check_val($sformatf("%s out_push c%0d", name, c), bus.out_push, p2 != 4'b0000);
            if (p2 != 4'b0000) begin
                ch = onehot_idx(p2);
                check_val($sformatf("%s out_data c%0d", name, c), bus.out_data, word(ch, seq_m[ch]));
                seq_m[ch]++;
            end
            if (p1 != 4'b0000) last_gid = 2'(onehot_idx(p1));
            check_val($sformatf("%s grant_id c%0d", name, c), grant_id, last_gid);
            check_val($sformatf("%s busy c%0d", name, c), busy, (p1 != 4'b0000) || (p2 != 4'b0000));
            if (c >= 1 && c - 1 < n && v_st[c-1] != ST_DC)
                check_val($sformatf("%s state c%0d", name, c - 1), arb_state, v_st[c-1]);
            hist[c] = ep;
            next_cycle();
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        // Held in reset with work present: everything must stay quiet
        reset               = 1'b0;
        arb_en              = 1'b1;
        bus.in_empty        = 4'h0;
        bus.out_almost_full = 1'b0;
        @(negedge clk);
        check_val("rst in_pop", bus.in_pop, 4'h0);
        check_val("rst out_push", bus.out_push, 1'b0);
        check_val("rst out_data", bus.out_data, '0);
        check_val("rst grant_id", grant_id, 2'd0);
        check_val("rst busy", busy, 1'b0);

        // All channels empty: nothing happens
        do_reset();
        for (int c = 0; c < 10; c++) set_row(c, 4'hF, 1'b0, 1'b1, 4'h0, ST_IDLE);
        run_vec("empty", 10);

`ifdef ARB_BURST_EN
        // Bursts of 4, then channel 2 drains after 2 grants
        do_reset();
        for (int c = 0; c < 12; c++) set_row(c, (c >= 10) ? 4'b0100 : 4'h0, 1'b0, 1'b1, 4'h0, ST_SERVE);
        v_pop[0] = 4'h1;  v_pop[1] = 4'h1;  v_pop[2]  = 4'h1;  v_pop[3]  = 4'h1;
        v_pop[4] = 4'h2;  v_pop[5] = 4'h2;  v_pop[6]  = 4'h2;  v_pop[7]  = 4'h2;
        v_pop[8] = 4'h4;  v_pop[9] = 4'h4;  v_pop[10] = 4'h8;  v_pop[11] = 4'h8;
        run_vec("burst", 12);

        // Back-pressure mid-burst: counter survives the stall
        do_reset();
        set_row(0, 4'h0, 1'b0, 1'b1, 4'h1, ST_SERVE);
        set_row(1, 4'h0, 1'b0, 1'b1, 4'h1, ST_SERVE);
        set_row(2, 4'h0, 1'b1, 1'b1, 4'h0, ST_STALL);
        set_row(3, 4'h0, 1'b1, 1'b1, 4'h0, ST_STALL);
        set_row(4, 4'h0, 1'b1, 1'b1, 4'h0, ST_STALL);
        set_row(5, 4'h0, 1'b0, 1'b1, 4'h1, ST_SERVE);
        set_row(6, 4'h0, 1'b0, 1'b1, 4'h1, ST_SERVE);
        set_row(7, 4'h0, 1'b0, 1'b1, 4'h2, ST_SERVE);
        run_vec("stall", 8);
`else
        // Strict round robin over four busy channels
        do_reset();
        set_row(0, 4'h0, 1'b0, 1'b1, 4'h1, ST_SERVE);
        set_row(1, 4'h0, 1'b0, 1'b1, 4'h2, ST_SERVE);
        set_row(2, 4'h0, 1'b0, 1'b1, 4'h4, ST_SERVE);
        set_row(3, 4'h0, 1'b0, 1'b1, 4'h8, ST_SERVE);
        set_row(4, 4'h0, 1'b0, 1'b1, 4'h1, ST_SERVE);
        set_row(5, 4'h0, 1'b0, 1'b1, 4'h2, ST_SERVE);
        run_vec("rr", 6);

        // Back-pressure for 3 cycles, round robin resumes at the next channel
        do_reset();
        set_row(0, 4'h0, 1'b0, 1'b1, 4'h1, ST_SERVE);
        set_row(1, 4'h0, 1'b0, 1'b1, 4'h2, ST_SERVE);
        set_row(2, 4'h0, 1'b1, 1'b1, 4'h0, ST_STALL);
        set_row(3, 4'h0, 1'b1, 1'b1, 4'h0, ST_STALL);
        set_row(4, 4'h0, 1'b1, 1'b1, 4'h0, ST_STALL);
        set_row(5, 4'h0, 1'b0, 1'b1, 4'h4, ST_SERVE);
        set_row(6, 4'h0, 1'b0, 1'b1, 4'h8, ST_SERVE);
        set_row(7, 4'h0, 1'b0, 1'b1, 4'h1, ST_SERVE);
        run_vec("stall", 8);
`endif

        // Only channel 2 has data; arb_en drops in row 4, sparse channel 1 after
        do_reset();
        set_row(0, 4'b1011, 1'b0, 1'b1, 4'h4, ST_SERVE);
        set_row(1, 4'b1011, 1'b0, 1'b1, 4'h4, ST_SERVE);
        set_row(2, 4'b1011, 1'b0, 1'b1, 4'h4, ST_SERVE);
        set_row(3, 4'b1011, 1'b0, 1'b1, 4'h4, ST_SERVE);
        set_row(4, 4'b1011, 1'b0, 1'b0, 4'h0, ST_IDLE);
        set_row(5, 4'b1011, 1'b0, 1'b0, 4'h0, ST_IDLE);
        set_row(6, 4'b1101, 1'b0, 1'b1, 4'h2, ST_SERVE);
        set_row(7, 4'b1111, 1'b0, 1'b1, 4'h0, ST_IDLE);
        run_vec("single", 8);

        // Asynchronous reset while words are in flight
        do_reset();
        bus.in_empty = 4'h0;
        arb_en       = 1'b1;
        next_cycle();
        next_cycle();
        @(negedge clk);
        check_val("pre-rst busy", busy, 1'b1);
        check_val("pre-rst out_push", bus.out_push, 1'b1);
        check_val("pre-rst out_data", bus.out_data, word(0, 0));
        #1;
        reset = 1'b0;
        #1;
        check_val("async in_pop", bus.in_pop, 4'h0);
        check_val("async out_push", bus.out_push, 1'b0);
        check_val("async out_data", bus.out_data, '0);
        check_val("async grant_id", grant_id, 2'd0);
        check_val("async busy", busy, 1'b0);
        check_val("async state", arb_state, ST_IDLE);
        next_cycle();
        reset = 1'b1;
        @(negedge clk);
        check_val("post-rst first pop", bus.in_pop, 4'h1);
        check_val("post-rst no stale push", bus.out_push, 1'b0);
        next_cycle();
        @(negedge clk);
        check_val("post-rst second pop", bus.in_pop, 4'h2);
        check_val("post-rst dropped push", bus.out_push, 1'b0);
        check_val("post-rst busy", busy, 1'b1);
        next_cycle();
        @(negedge clk);
        check_val("post-rst push", bus.out_push, 1'b1);
        check_val("post-rst data", bus.out_data, word(0, 0));

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end
endmodule
